vca_mul_scheduler: RTL
======================

# vca_mul_scheduler

Time-multiplexed dual-channel VCA engine that shares one pipelined signed 16x16 multiplier between both gain/signal channel pairs. On each rising edge of `sample_clk` it snapshots the four inputs and issues the two products back-to-back into the shared multiplier. It commits all four outputs on a single `clk` edge. It sits between the codec sample interface and downstream cores, replacing two parallel multipliers with one DSP resource.

## Interface
Parameters:
- `W`, 16: sample width, signed two's complement.
- `MUL_LATENCY`, 2: register stages inside the shared multiplier, range 1..4.

Ports:
- `clk`  in  1: system clock, 12 MHz.
- `rst`  in  1: asynchronous, active-high reset.
- `sample_clk`  in  1: sample-rate clock, synchronous to `clk`, high and low phases each at least 1 `clk` cycle.
- `sample_in0`  in  W: gain, channel A.
- `sample_in1`  in  W: signal, channel A.
- `sample_in2`  in  W: gain, channel B.
- `sample_in3`  in  W: signal, channel B.
- `sample_out0`  out  W: snapshot of `sample_in0`.
- `sample_out1`  out  W: (in0·in1) >>> 16.
- `sample_out2`  out  W: snapshot of `sample_in2`.
- `sample_out3`  out  W: (in2·in3) >>> 16.
- `busy`  out  1: high while a frame is in flight.
- `overrun`  out  1: sticky; set when a strobe arrives while busy.

## Operation
- **Edge detect**
  - `s_q <= sample_clk`, with reset value 1 so that `sample_clk` high at reset release does not strobe.
  - `strobe = sample_clk & ~s_q`.
- **FSM states:** IDLE, ISSUE, DRAIN, COMMIT.
  - IDLE: on `strobe`, capture `sample_in0..3` into snapshot registers, clear the issue index, and go to ISSUE.
  - ISSUE: 2 cycles. Index 0 presents (snap0, snap1) to the multiplier; index 1 presents (snap2, snap3). Then go to DRAIN.
  - DRAIN: MUL_LATENCY−1 cycles, counted by a down-counter. If MUL_LATENCY=1, go straight to COMMIT.
  - COMMIT: 1 cycle. Write all four outputs simultaneously, then return to IDLE.
- **Result capture:** each multiplier output, when its valid tag is high, is written to the result register selected by the tag's index. A valid/index tag travels alongside the multiplier pipeline.
- **Arithmetic**
  - Full 2W-bit signed product.
  - Output is bits [2W−1:16], an arithmetic shift right by 16 (floor toward −∞). No rounding.
  - Saturation is unnecessary: (−32768)·(−32768)>>>16 = 16384 fits in W.
- **Outputs 0/2** are the snapshot values, not live inputs. They update only at COMMIT, aligned with outputs 1/3.
- **busy** = (state != IDLE).
- **Overrun**
  - A strobe while state != IDLE is dropped and sets `overrun`.
  - `overrun` is cleared only by `rst`.
  - The in-flight frame completes unaffected.
- **Reset, any time, mid-frame included:** state→IDLE; outputs, snapshots, results and multiplier pipeline/tags→0; `busy`=0; `overrun`=0. No partial frame is ever committed.

## Timing
- E0 is the `clk` edge on which `strobe` is high in IDLE.
- ISSUE occupies the cycles after E0 and E0+1.
- Outputs change at edge E0+2+MUL_LATENCY, which is E0+4 with defaults. The FSM returns to IDLE on the same edge.
- `busy` is high from E0 through E0+2+MUL_LATENCY.
- Minimum `sample_clk` period is 3+MUL_LATENCY `clk` cycles for zero overrun. This is trivially met at codec rates (≥250 cycles).
- Outputs are held constant between commits.

## Structure
- **Package `vca_sched_pkg`** holds:
  - the state enum (IDLE, ISSUE, DRAIN, COMMIT);
  - `N_PAIRS = 2`;
  - the shift constant `PROD_SHIFT = 16`.
- **Sub-module `shared_mul`**: parameterised (W, MUL_LATENCY) signed pipelined multiplier.
  - Carries a valid bit and a 1-bit index alongside the data.
  - No reset on data stages; valid stages use the async reset.

## Test plan
- Reset release with `sample_clk`=1 → no strobe, `busy`=0, all outputs 0.
- Inputs (16384, 16384, −32768, −32768), one `sample_clk` rise → at E0+4: out0=16384, out1=4096, out2=−32768, out3=16384, all on the same edge. `busy` high for exactly 5 edges.
- Inputs (−32768, 32767, 1, −1) → out1=−16384, out3=−1 (floor semantics).
- Inputs change every cycle after E0 → outputs reflect only the E0 snapshot.
- Second `sample_clk` rise at E0+2 → `overrun`=1 and stays set, the first frame commits correct values, and no second commit occurs.
- `rst` pulsed at E0+2 → outputs stay 0, `busy`=0, and the next strobe produces a normal frame.

Source files
------------

// File: rtl/vca_sched_pkg.sv
// Shared types and constants for the time-multiplexed VCA engine.
package vca_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StCommit
    } state_e;

    localparam int unsigned N_PAIRS    = 2;
    localparam int unsigned PROD_SHIFT = 16;

endpackage

// File: rtl/vca_mul_scheduler_if.sv
// Codec-side sample bus: four inputs in, four committed outputs plus status out.
interface vca_mul_scheduler_if #(
    parameter int unsigned W = 16
) ();

    logic                sample_clk;
    logic signed [W-1:0] sample_in0;
    logic signed [W-1:0] sample_in1;
    logic signed [W-1:0] sample_in2;
    logic signed [W-1:0] sample_in3;
    logic signed [W-1:0] sample_out0;
    logic signed [W-1:0] sample_out1;
    logic signed [W-1:0] sample_out2;
    logic signed [W-1:0] sample_out3;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
        input  sample_out0, sample_out1, sample_out2, sample_out3, busy, overrun
    );

    modport slave (
        input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
        output sample_out0, sample_out1, sample_out2, sample_out3, busy, overrun
    );

endinterface

// File: rtl/shared_mul.sv
// Pipelined signed multiplier returning (a*b) >>> PROD_SHIFT, with a valid/index tag
// travelling alongside the data so results can be steered at the far end.
module shared_mul
    import vca_sched_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                in_valid,
    input  logic                in_idx,
    output logic signed [W-1:0] prod,
    output logic                out_valid,
    output logic                out_idx
);

    logic signed [2*W-1:0]   full;
    logic signed [W-1:0]     data_q [MUL_LATENCY];
    logic [MUL_LATENCY-1:0]  vld_q;
    logic [MUL_LATENCY-1:0]  idx_q;
    logic                    unused_lsbs;

    // Sign-extend both operands so the product is the full 2W-bit signed result.
    assign full        = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    assign unused_lsbs = ^full[PROD_SHIFT-1:0];

    // Data stages carry no reset; the valid tag alone decides whether they matter.
    always_ff @(posedge clk) begin
        data_q[0] <= full[PROD_SHIFT +: W];
        for (int i = 1; i < MUL_LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    // Valid/index tag pipeline, cleared on reset so no stale result is ever captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            idx_q[0] <= in_idx;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign prod      = data_q[MUL_LATENCY-1];
    assign out_valid = vld_q[MUL_LATENCY-1];
    assign out_idx   = idx_q[MUL_LATENCY-1];

endmodule

// File: rtl/vca_mul_scheduler.sv
// Dual-channel VCA: snapshots both gain/signal pairs on a sample_clk rise, runs them
// back-to-back through one shared multiplier and commits all four outputs together.
module vca_mul_scheduler
    import vca_sched_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned MUL_LATENCY = 2
) (
    input logic                clk,
    input logic                rst,
    vca_mul_scheduler_if.slave bus
);

    logic                s_q;
    logic                strobe;
    state_e              state;
    logic                issue_idx;
    logic [2:0]          drain_cnt;
    logic                overrun_q;
    logic signed [W-1:0] snap    [2*N_PAIRS];
    logic signed [W-1:0] res     [N_PAIRS];
    logic signed [W-1:0] res_now [N_PAIRS];

    logic signed [W-1:0] mul_a;
    logic signed [W-1:0] mul_b;
    logic                mul_valid;
    logic signed [W-1:0] prod;
    logic                prod_valid;
    logic                prod_idx;

    // Rising-edge detect on sample_clk; resets high so a high level at release is not a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= 1'b1;
        end else begin
            s_q <= bus.sample_clk;
        end
    end

    assign strobe = bus.sample_clk & ~s_q;

    assign mul_valid = (state == StIssue);
    assign mul_a     = issue_idx ? snap[2] : snap[0];
    assign mul_b     = issue_idx ? snap[3] : snap[1];

    shared_mul #(
        .W           (W),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .a         (mul_a),
        .b         (mul_b),
        .in_valid  (mul_valid),
        .in_idx    (issue_idx),
        .prod      (prod),
        .out_valid (prod_valid),
        .out_idx   (prod_idx)
    );

    // Steer each tagged multiplier result into its pair's result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PAIRS; i++) begin
                res[i] <= '0;
            end
        end else if (prod_valid) begin
            res[prod_idx] <= prod;
        end
    end

    // The last pair's product leaves the multiplier on the commit edge itself, so bypass it.
    always_comb begin
        for (int i = 0; i < N_PAIRS; i++) begin
            res_now[i] = (prod_valid && (prod_idx == 1'(i))) ? prod : res[i];
        end
    end

    // Frame sequencer with registered outputs and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            issue_idx       <= 1'b0;
            drain_cnt       <= '0;
            overrun_q       <= 1'b0;
            bus.sample_out0 <= '0;
            bus.sample_out1 <= '0;
            bus.sample_out2 <= '0;
            bus.sample_out3 <= '0;
            for (int i = 0; i < 2 * N_PAIRS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            if (strobe && (state != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (strobe) begin
                        snap[0]   <= bus.sample_in0;
                        snap[1]   <= bus.sample_in1;
                        snap[2]   <= bus.sample_in2;
                        snap[3]   <= bus.sample_in3;
                        issue_idx <= 1'b0;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    issue_idx <= 1'b1;
                    if (issue_idx) begin
                        if (MUL_LATENCY > 1) begin
                            drain_cnt <= 3'(MUL_LATENCY - 2);
                            state     <= StDrain;
                        end else begin
                            state <= StCommit;
                        end
                    end
                end
                StDrain: begin
                    if (drain_cnt == '0) begin
                        state <= StCommit;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                StCommit: begin
                    bus.sample_out0 <= snap[0];
                    bus.sample_out1 <= res_now[0];
                    bus.sample_out2 <= snap[2];
                    bus.sample_out3 <= res_now[1];
                    state           <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy    = (state != StIdle);
    assign bus.overrun = overrun_q;

endmodule
